// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: sequencer for the 3x3 convolution weight-register array.
// For each kernel it fetches the weights, then scans the kernel window
// (x, y) and the output position (X, Y) over the feature map. It drives the
// weight load/shift/return strobes and the accumulator window markers.
module conv_scan_ctrl #(
   parameter int KSIZE = 3,
   parameter int OSIZE = 19,
   parameter int KW    = 2,
   parameter int PW    = 5,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          xrst,
   input  logic          start,
   input  logic [AW-1:0] num_k,
   input  logic          hold,
   output logic [AW-1:0] raddr,
   output logic          load_w,
   output logic [KW-1:0] x,
   output logic [KW-1:0] y,
   output logic [PW-1:0] X,
   output logic [PW-1:0] Y,
   output logic          valid,
   output logic          win_first,
   output logic          win_last,
   output logic          shift_x,
   output logic          shift_y,
   output logic          ret_w,
   output logic          busy,
   output logic          finish
);

   localparam logic [KW-1:0] K_MAX = KW'(KSIZE - 1);
   localparam logic [PW-1:0] O_MAX = PW'(OSIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_ADDR,
      S_LOAD_DATA,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state;
   logic [AW-1:0] k;
   logic [AW-1:0] nk;

   logic step;
   logic x_end;
   logic y_end;
   logic xo_end;
   logic yo_end;
   logic last;

   assign raddr  = k;
   assign step   = (state == S_RUN) && !hold;
   assign x_end  = (x == K_MAX);
   assign y_end  = (y == K_MAX);
   assign xo_end = (X == O_MAX);
   assign yo_end = (Y == O_MAX);
   assign last   = x_end && y_end && xo_end && yo_end;

   // Weight-movement strobes and window markers from the current position.
   always_comb begin
      shift_x   = step && !x_end;
      shift_y   = step && x_end && !y_end;
      ret_w     = step && x_end && y_end;
      win_first = valid && (x == '0) && (y == '0);
      win_last  = valid && x_end && y_end;
   end

   // Control FSM with registered status outputs and the scan counters.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state  <= S_IDLE;
         k      <= '0;
         nk     <= '0;
         x      <= '0;
         y      <= '0;
         X      <= '0;
         Y      <= '0;
         load_w <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         finish <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  nk    <= num_k;
                  k     <= '0;
                  x     <= '0;
                  y     <= '0;
                  X     <= '0;
                  Y     <= '0;
                  busy  <= 1'b1;
                  state <= S_LOAD_ADDR;
               end
            end
            S_LOAD_ADDR: begin
               load_w <= 1'b1;
               state  <= S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
               load_w <= 1'b0;
               valid  <= 1'b1;
               state  <= S_RUN;
            end
            S_RUN: begin
               if (!hold) begin
                  // x fastest, then y, X, Y; each wraps and carries onward
                  if (!x_end) begin
                     x <= x + 1'b1;
                  end else begin
                     x <= '0;
                     if (!y_end) begin
                        y <= y + 1'b1;
                     end else begin
                        y <= '0;
                        if (!xo_end) begin
                           X <= X + 1'b1;
                        end else begin
                           X <= '0;
                           Y <= yo_end ? '0 : Y + 1'b1;
                        end
                     end
                  end
                  if (last) begin
                     valid <= 1'b0;
                     if (k == nk) begin
                        finish <= 1'b1;
                        state  <= S_DONE;
                     end else begin
                        k     <= k + 1'b1;
                        state <= S_LOAD_ADDR;
                     end
                  end
               end
            end
            S_DONE: begin
               finish <= 1'b0;
               busy   <= 1'b0;
               k      <= '0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
